stage2_relu_pool: RTL and testbench

- Downstream consumer of the six-channel adder stage in the LeNet-5 conv2 datapath.
- Takes the per-pixel channel sum stream in raster order, adds the per-filter bias, applies ReLU and performs 2x2/stride-2 max pooling.
- Emits the pooled map, 10x10 -> 5x5 by default, to the next layer's feature buffer.
- One instance per conv2 filter.

---
 rtl/stage2_relu_pool_pkg.sv | 21 ++
 rtl/stage2_relu_pool_if.sv | 22 ++
 rtl/stage2_relu_pool_line_buf.sv | 22 ++
 rtl/stage2_relu_pool.sv | 121 ++++++++++++
 tb/tb_stage2_relu_pool.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/stage2_relu_pool_pkg.sv
// Shared LeNet-5 constants and the saturating bias-add/ReLU helper.
// Used by the conv1 and conv2 pooling stages.
package lenet_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam int C2_W = 10;
    localparam int C2_H = 10;
    localparam int P2_W = 5;
    localparam int P2_H = 5;

    // sum arrives sign-extended to 33 bits; result is clamped to [0, 2^(width-1)-1].
    function automatic logic signed [31:0] sat_relu(input logic signed [32:0] sum, input int width);
        logic signed [32:0] max_v;
        max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
        if (sum < 33'sd0) return '0;
        if (sum > max_v) return max_v[31:0];
        return sum[31:0];
    endfunction

endpackage

// File: rtl/stage2_relu_pool_if.sv
// Pixel-in / pooled-out stream bundle between the channel adder, the pool stage and the feature buffer.
// No ready signal: the consumer must accept every out_valid.
interface stage2_relu_pool_if #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH_DEF
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] datain;
    logic signed [DATA_WIDTH-1:0] bias;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] dataout;
    logic                         frame_done;

    modport master (
        output in_valid, datain, bias,
        input  out_valid, dataout, frame_done
    );

    modport slave (
        input  in_valid, datain, bias,
        output out_valid, dataout, frame_done
    );
endinterface

// File: rtl/stage2_relu_pool_line_buf.sv
// Half-row buffer of horizontal maxima from the even row of a pooling window pair.
// Synchronous write, combinational read; contents are always written before they are read.
module pool_line_buf #(
    parameter int DEPTH      = 5,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);
    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/stage2_relu_pool.sv
// Bias add + saturating ReLU + 2x2/stride-2 max pool for one conv2 filter, raster-order input.
// Output 2 cycles after a window's bottom-right pixel; no backpressure, every out_valid must be taken.
module stage2_relu_pool
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FMAP_W     = C2_W,
    parameter int FMAP_H     = C2_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    stage2_relu_pool_if.slave     io
);
    localparam int HALF_W = FMAP_W / 2;
    localparam int CW     = $clog2(FMAP_W);
    localparam int RW     = $clog2(FMAP_H);
    localparam int LAW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if ((FMAP_W % 2) != 0 || (FMAP_H % 2) != 0 || FMAP_W < 2 || FMAP_H < 2) begin : g_bad_dims
        $error("stage2_relu_pool: FMAP_W and FMAP_H must be even and >= 2");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
        $error("stage2_relu_pool: DATA_WIDTH must be in 2..32");
    end

    logic                         a_vld_q, a_vld_d;
    logic signed [DATA_WIDTH-1:0] a_val_q, a_val_d;
    logic signed [DATA_WIDTH-1:0] hmax_q, hmax_d;
    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] dataout_q, dataout_d;
    logic                         frame_done_q, frame_done_d;

    logic signed [DATA_WIDTH:0]   sum_w;
    logic signed [DATA_WIDTH-1:0] pm, lb_rdata;
    logic [LAW-1:0]               lb_addr;
    logic                         lb_we, col_last, row_last;

    assign sum_w    = $signed({io.datain[DATA_WIDTH-1], io.datain}) + $signed({io.bias[DATA_WIDTH-1], io.bias});
    assign col_last = (col_q == CW'(FMAP_W - 1));
    assign row_last = (row_q == RW'(FMAP_H - 1));
    assign pm       = (a_val_q > hmax_q) ? a_val_q : hmax_q;
    assign lb_addr  = LAW'(col_q >> 1);
    // Even rows park the horizontal max; the odd row below reads it back at the same column pair.
    assign lb_we    = a_vld_q && col_q[0] && !row_q[0] && !clear;

    pool_line_buf #(
        .DEPTH      (HALF_W),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (LAW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pm),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        a_vld_d      = io.in_valid;
        a_val_d      = a_val_q;
        hmax_d       = hmax_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        dataout_d    = dataout_q;
        frame_done_d = 1'b0;

        if (io.in_valid) a_val_d = DATA_WIDTH'(sat_relu(33'(sum_w), DATA_WIDTH));

        if (clear) begin
            a_vld_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
        end else if (a_vld_q) begin
            if (!col_q[0]) begin
                hmax_d = a_val_q;
            end else if (row_q[0]) begin
                dataout_d    = (lb_rdata > pm) ? lb_rdata : pm;
                out_valid_d  = 1'b1;
                frame_done_d = row_last && col_last;
            end

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld_q      <= 1'b0;
            a_val_q      <= '0;
            hmax_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            dataout_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            a_vld_q      <= a_vld_d;
            a_val_q      <= a_val_d;
            hmax_q       <= hmax_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            dataout_q    <= dataout_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.dataout    = dataout_q;
    assign io.frame_done = frame_done_q;
endmodule

// File: tb/tb_stage2_relu_pool.sv
// Self-checking bench for stage2_relu_pool: ramp, constant-frame table, gaps, clear and async reset.
module tb_stage2_relu_pool;

    typedef struct {
        int val;
        int cyc;
        bit last;
    } exp_t;

    typedef struct {
        logic signed [15:0] d;
        logic signed [15:0] b;
        int                 exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;

    stage2_relu_pool_if #(.DATA_WIDTH(16)) bus ();

    stage2_relu_pool #(
        .DATA_WIDTH (16),
        .FMAP_W     (10),
        .FMAP_H     (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   m_r = 0;
    int   m_c = 0;
    int   exp_frames = 0;
    int   fd_seen = 0;
    int   last_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every out_valid must match the oldest expected window.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) fd_seen++;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dataout", int'(bus.dataout), e.val);
                    check("out_cycle", cyc, e.cyc);
                    check("frame_done", int'(bus.frame_done), int'(e.last));
                    last_out = e.val;
                end
            end else begin
                if (bus.frame_done) check("frame_done_without_out_valid", 1, 0);
                check("dataout_hold", int'(bus.dataout), last_out);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.datain   = 16'($urandom);
    endtask

    task automatic send_px(input logic signed [15:0] d, input logic signed [15:0] b, input int exp);
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.datain   = d;
        bus.bias     = b;
        if (m_r[0] && m_c[0]) begin
            e.val  = exp;
            e.cyc  = cyc + 2;
            e.last = (m_r == 9 && m_c == 9);
            sb.push_back(e);
            if (e.last) exp_frames++;
        end
        if (m_c == 9) begin
            m_c = 0;
            m_r = (m_r == 9) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    // Ramp pixel(r,c)=10r+c with bias 0 pools to 20i+2j+11; otherwise a constant frame.
    task automatic send_frame(input bit ramp, input logic signed [15:0] d, input logic signed [15:0] b,
                              input int exp, input bit gaps, input int npix);
        for (int k = 0; k < npix; k++) begin
            int r, c;
            r = k / 10;
            c = k % 10;
            for (int g = 0; g < 3 && gaps && $urandom_range(0, 1) == 1; g++) idle();
            if (ramp) send_px(16'(10 * r + c), 16'sd0, 20 * (r / 2) + 2 * (c / 2) + 11);
            else      send_px(d, b, exp);
        end
    endtask

    // Drop expected entries that would appear at or after the given cycle.
    task automatic flush_from(input int from_cyc);
        while (sb.size() > 0 && sb[sb.size() - 1].cyc >= from_cyc) begin
            if (sb[sb.size() - 1].last) exp_frames--;
            void'(sb.pop_back());
        end
    endtask

    vec_t tab[8];

    initial begin
        tab[0] = '{d: -16'sd500,  b: 16'sd100,    exp: 0};
        tab[1] = '{d: 16'sd32000, b: 16'sd1000,   exp: 32767};
        tab[2] = '{d: -16'sd1,    b: -16'sd32768, exp: 0};
        tab[3] = '{d: 16'sd100,   b: -16'sd30,    exp: 70};
        tab[4] = '{d: 16'sd32767, b: 16'sd32767,  exp: 32767};
        tab[5] = '{d: -16'sd32768, b: -16'sd32768, exp: 0};
        tab[6] = '{d: 16'sd5,     b: -16'sd5,     exp: 0};
        tab[7] = '{d: -16'sd7,    b: 16'sd1234,   exp: 1227};

        bus.in_valid = 1'b0;
        bus.datain   = '0;
        bus.bias     = '0;

        #12;
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_dataout", int'(bus.dataout), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        rst = 1'b0;

        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 100);
        repeat (4) idle();

        for (int t = 0; t < 8; t++) begin
            send_frame(1'b0, tab[t].d, tab[t].b, tab[t].exp, 1'b0, 100);
        end
        repeat (4) idle();

        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b1, 100);
        repeat (4) idle();

        // Abort after pixel 57; the clear cycle also carries a pixel that must be dropped.
        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 58);
        @(posedge clk); #1;
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.datain   = 16'sd9999;
        flush_from(cyc + 1);
        m_r = 0;
        m_c = 0;
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 100);
        repeat (4) idle();

        // Async reset between edges while the window ending at pixel 39 is on the output.
        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 40);
        idle();
        @(posedge clk); #3;
        check("pre_reset_out_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        flush_from(cyc);
        #1;
        check("midreset_out_valid", int'(bus.out_valid), 0);
        check("midreset_dataout", int'(bus.dataout), 0);
        check("midreset_frame_done", int'(bus.frame_done), 0);
        last_out = 0;
        m_r = 0;
        m_c = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 100);
        send_frame(1'b1, 16'sd0, 16'sd0, 0, 1'b0, 100);
        repeat (6) idle();

        check("scoreboard_drained", sb.size(), 0);
        check("frame_done_count", fd_seen, exp_frames);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
